// File: rtl/addr_seq_pkg.sv
// Shared types for the RAM address sequencer: command codes, FSM states and
// the bundle of registered strobes/flags carried by the output stage.
package addr_seq_pkg;

  localparam int CMD_W = 3;

  typedef enum logic [CMD_W-1:0] {
    CMD_HOLD  = 3'd0,
    CMD_LOAD  = 3'd1,
    CMD_INC   = 3'd2,
    CMD_DEC   = 3'd3,
    CMD_BURST = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic rd;
    logic wr;
    logic busy;
    logic done;
    logic wrap;
    logic err;
    logic conflict;
  } flags_t;

endpackage

// File: rtl/addr_seq_reg.sv
// Output register stage: holds the RAM address together with its aligned
// strobes and one-cycle flag pulses; cleared asynchronously on reset.
module addr_seq_reg
  import addr_seq_pkg::*;
#(
  parameter int SIZE_ADDR = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [SIZE_ADDR-1:0] i_addr_d,
  input  flags_t               i_flags_d,
  output logic [SIZE_ADDR-1:0] o_addr_q,
  output flags_t               o_flags_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_addr_q  <= '0;
      o_flags_q <= '0;
    end else begin
      o_addr_q  <= i_addr_d;
      o_flags_q <= i_flags_d;
    end
  end

endmodule

// File: rtl/addr_seq_gen.sv
// RAM address sequencer: source select, inc/dec with wrap, and an autonomous
// read sweep with stall/abort. Next-state logic here, outputs in addr_seq_reg.
module addr_seq_gen
  import addr_seq_pkg::*;
#(
  parameter int SIZE_ADDR = 8,
  parameter int DEPTH     = 256,
  parameter int NUM_SRC   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_cmd_valid,
  input  logic [CMD_W-1:0]               i_cmd,
  input  logic [$clog2(NUM_SRC)-1:0]     i_sel_src,
  input  logic [NUM_SRC*SIZE_ADDR-1:0]   i_src_addr,
  input  logic [SIZE_ADDR-1:0]           i_burst_last,
  input  logic                           i_rd_en,
  input  logic                           i_wr_en,
  input  logic                           i_stall,
  input  logic                           i_abort,
  output logic [SIZE_ADDR-1:0]           o_addr_ram,
  output logic                           o_rd_en,
  output logic                           o_wr_en,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_wrap,
  output logic                           o_err,
  output logic                           o_conflict
);

  localparam int SEL_W = $clog2(NUM_SRC);
  localparam logic [SIZE_ADDR-1:0] LAST_ADDR = SIZE_ADDR'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > (1 << SIZE_ADDR)) begin : g_bad_depth
    $error("addr_seq_gen: DEPTH must lie in [2, 2**SIZE_ADDR]");
  end
  if (NUM_SRC < 2) begin : g_bad_src
    $error("addr_seq_gen: NUM_SRC must be at least 2");
  end

  state_e               state_q, state_d;
  logic [SIZE_ADDR-1:0] ptr_q, ptr_d;
  logic [SIZE_ADDR-1:0] last_q, last_d;
  logic [SIZE_ADDR-1:0] addr_q, addr_d;
  logic [SIZE_ADDR-1:0] src_val;
  logic                 src_ok;
  flags_t               flags_d, flags_q;

  // Non-power-of-two NUM_SRC leaves selector codes with no source behind them.
  always_comb begin
    src_val = '0;
    src_ok  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (i_sel_src == SEL_W'(k)) begin
        src_val = i_src_addr[k*SIZE_ADDR +: SIZE_ADDR];
        src_ok  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    addr_d  = addr_q;
    flags_d = '0;

    case (state_q)
      ST_IDLE: begin
        flags_d.wr       = i_wr_en;
        flags_d.rd       = i_rd_en & ~i_wr_en;
        flags_d.conflict = i_rd_en & i_wr_en;
        if (i_cmd_valid) begin
          case (cmd_e'(i_cmd))
            CMD_HOLD: ;
            CMD_LOAD: begin
              if (src_ok && (src_val <= LAST_ADDR)) addr_d = src_val;
              else                                  flags_d.err = 1'b1;
            end
            CMD_INC: begin
              if (addr_q == LAST_ADDR) begin
                addr_d       = '0;
                flags_d.wrap = 1'b1;
              end else begin
                addr_d = addr_q + 1'b1;
              end
            end
            CMD_DEC: begin
              if (addr_q == '0) begin
                addr_d       = LAST_ADDR;
                flags_d.wrap = 1'b1;
              end else begin
                addr_d = addr_q - 1'b1;
              end
            end
            CMD_BURST: begin
              if ((i_burst_last <= LAST_ADDR) && (i_burst_last >= addr_q)) begin
                state_d = ST_BURST;
                ptr_d   = addr_q;
                last_d  = i_burst_last;
              end else begin
                flags_d.err = 1'b1;
              end
            end
            default: flags_d.err = 1'b1;
          endcase
        end
      end

      // ptr_q is the next address to issue; the first issue repeats the start.
      ST_BURST: begin
        flags_d.busy = ~i_abort;
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (!i_stall) begin
          addr_d     = ptr_q;
          flags_d.rd = 1'b1;
          ptr_d      = ptr_q + 1'b1;
          if (ptr_q == last_q) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        flags_d.done = 1'b1;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    ptr_q  <= ptr_d;
    last_q <= last_d;
  end

  addr_seq_reg #(
    .SIZE_ADDR (SIZE_ADDR)
  ) u_reg (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_addr_d  (addr_d),
    .i_flags_d (flags_d),
    .o_addr_q  (addr_q),
    .o_flags_q (flags_q)
  );

  assign o_addr_ram = addr_q;
  assign o_rd_en    = flags_q.rd;
  assign o_wr_en    = flags_q.wr;
  assign o_busy     = flags_q.busy;
  assign o_done     = flags_q.done;
  assign o_wrap     = flags_q.wrap;
  assign o_err      = flags_q.err;
  assign o_conflict = flags_q.conflict;

endmodule

// File: tb/tb_addr_seq_gen.sv
// Directed bench for addr_seq_gen: one instance at DEPTH=256, one at DEPTH=200,
// both driven by the same stimulus.
module tb_addr_seq_gen;
  import addr_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic [1:0]  sel;
  logic [31:0] src;
  logic [7:0]  burst_last;
  logic        rd_en, wr_en, stall, abort;

  logic [7:0]  a_addr, b_addr;
  logic        a_rd, a_wr, a_busy, a_done, a_wrap, a_err, a_conflict;
  logic        b_rd, b_wr, b_busy, b_done, b_wrap, b_err, b_conflict;

  int checks   = 0;
  int failures = 0;
  int busy_cnt, done_cnt;

  bit [7:0] bst_addr  [10] = '{8'h10, 8'h10, 8'h11, 8'h12, 8'h12, 8'h12, 8'h13, 8'h14, 8'h14, 8'h14};
  bit       bst_rd    [10] = '{0, 1, 1, 1, 0, 0, 1, 1, 0, 0};
  bit       bst_busy  [10] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
  bit       bst_done  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
  bit       bst_stall [10] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};

  addr_seq_gen #(.SIZE_ADDR(8), .DEPTH(256), .NUM_SRC(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_sel_src(sel), .i_src_addr(src), .i_burst_last(burst_last),
    .i_rd_en(rd_en), .i_wr_en(wr_en), .i_stall(stall), .i_abort(abort),
    .o_addr_ram(a_addr), .o_rd_en(a_rd), .o_wr_en(a_wr), .o_busy(a_busy),
    .o_done(a_done), .o_wrap(a_wrap), .o_err(a_err), .o_conflict(a_conflict)
  );

  addr_seq_gen #(.SIZE_ADDR(8), .DEPTH(200), .NUM_SRC(4)) dut200 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
    .i_sel_src(sel), .i_src_addr(src), .i_burst_last(burst_last),
    .i_rd_en(rd_en), .i_wr_en(wr_en), .i_stall(stall), .i_abort(abort),
    .o_addr_ram(b_addr), .o_rd_en(b_rd), .o_wr_en(b_wr), .o_busy(b_busy),
    .o_done(b_done), .o_wrap(b_wrap), .o_err(b_err), .o_conflict(b_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    cmd_valid = 1'b0;
    cmd       = CMD_HOLD;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    stall     = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] s);
    cmd_valid = 1'b1;
    cmd       = c;
    sel       = s;
    tick();
    quiet();
  endtask

  initial begin
    quiet();
    sel        = 2'd0;
    src        = {8'h10, 8'h35, 8'hC8, 8'hFF};
    burst_last = 8'h00;
    rst_n      = 1'b0;
    tick();
    tick();
    check_val("reset_outs", {a_addr, a_rd, a_wr, a_busy, a_done, a_wrap, a_err, a_conflict}, 32'h0);
    rst_n = 1'b1;
    tick();

    rd_en = 1'b1;
    issue(CMD_LOAD, 2'd2);
    check_val("load_addr", a_addr, 8'h35);
    check_val("load_rd", a_rd, 1);
    check_val("load_wr", a_wr, 0);
    tick();
    check_val("rd_pulse_end", a_rd, 0);
    check_val("addr_hold", a_addr, 8'h35);

    #3 rst_n = 1'b0;
    #1 check_val("rst_async", {a_addr, a_rd, a_wr, a_busy, a_done, a_wrap, a_err, a_conflict}, 32'h0);
    #1 rst_n = 1'b1;

    issue(CMD_LOAD, 2'd0);
    check_val("load_ff", a_addr, 8'hFF);
    check_val("d200_load_ff_err", b_err, 1);
    check_val("d200_load_ff_addr", b_addr, 8'h00);
    issue(CMD_INC, 2'd0);
    check_val("inc_wrap_addr", a_addr, 8'h00);
    check_val("inc_wrap_flag", a_wrap, 1);
    tick();
    check_val("wrap_pulse_end", a_wrap, 0);
    issue(CMD_DEC, 2'd0);
    check_val("dec_wrap_addr", a_addr, 8'hFF);
    check_val("dec_wrap_flag", a_wrap, 1);
    tick();

    issue(CMD_LOAD, 2'd1);
    check_val("load_c8_addr", a_addr, 8'hC8);
    check_val("load_c8_noerr", a_err, 0);
    check_val("d200_c8_err", b_err, 1);
    check_val("d200_c8_addr", b_addr, 8'h00);
    tick();
    check_val("d200_err_end", b_err, 0);

    issue(3'd6, 2'd0);
    check_val("illegal_err", a_err, 1);
    check_val("illegal_addr", a_addr, 8'hC8);
    tick();
    check_val("illegal_err_end", a_err, 0);

    issue(CMD_LOAD, 2'd3);
    check_val("load_10", a_addr, 8'h10);

    // Burst 0x10..0x14, 2-cycle stall after 0x12, noise on strobes/cmd at step 2.
    burst_last = 8'h14;
    busy_cnt   = 0;
    done_cnt   = 0;
    for (int s = 0; s < 10; s++) begin
      cmd_valid = (s == 0) || (s == 2);
      cmd       = (s == 0) ? CMD_BURST : CMD_LOAD;
      sel       = 2'd2;
      rd_en     = (s == 2);
      wr_en     = (s == 2);
      stall     = bst_stall[s];
      tick();
      quiet();
      check_val($sformatf("bst_addr_%0d", s), a_addr, bst_addr[s]);
      check_val($sformatf("bst_rd_%0d", s), a_rd, bst_rd[s]);
      check_val($sformatf("bst_busy_%0d", s), a_busy, bst_busy[s]);
      check_val($sformatf("bst_done_%0d", s), a_done, bst_done[s]);
      check_val($sformatf("bst_wr_%0d", s), {a_wr, a_conflict}, 0);
      busy_cnt += int'(a_busy);
      done_cnt += int'(a_done);
    end
    check_val("bst_busy_cycles", busy_cnt, 7);
    check_val("bst_done_count", done_cnt, 1);

    // Burst 0x00..0x0F aborted (stall also high) after 0x05 has been issued.
    src = {8'h00, 8'h35, 8'hC8, 8'hFF};
    issue(CMD_LOAD, 2'd3);
    check_val("load_00", a_addr, 8'h00);
    burst_last = 8'h0F;
    done_cnt   = 0;
    for (int s = 0; s < 10; s++) begin
      cmd_valid = (s == 0);
      cmd       = CMD_BURST;
      abort     = (s == 7);
      stall     = (s == 7);
      tick();
      quiet();
      if (s == 0) begin
        check_val("abt_addr_0", a_addr, 8'h00);
        check_val("abt_rd_0", a_rd, 0);
      end else if (s <= 6) begin
        check_val($sformatf("abt_addr_%0d", s), a_addr, s - 1);
        check_val($sformatf("abt_rd_%0d", s), a_rd, 1);
        check_val($sformatf("abt_busy_%0d", s), a_busy, 1);
      end else begin
        check_val($sformatf("abt_addr_%0d", s), a_addr, 8'h05);
        check_val($sformatf("abt_rd_%0d", s), a_rd, 0);
        check_val($sformatf("abt_busy_%0d", s), a_busy, 0);
      end
      done_cnt += int'(a_done);
    end
    check_val("abt_no_done", done_cnt, 0);

    burst_last = 8'h03;
    issue(CMD_BURST, 2'd0);
    check_val("bst_back_err", a_err, 1);
    check_val("bst_back_addr", a_addr, 8'h05);
    tick();
    check_val("bst_back_idle", {a_busy, a_rd, a_err}, 0);

    burst_last = 8'h05;
    issue(CMD_BURST, 2'd0);
    check_val("one_accept", {a_addr, a_rd, a_err}, {8'h05, 1'b0, 1'b0});
    tick();
    check_val("one_read", {a_addr, a_rd, a_busy, a_done}, {8'h05, 1'b1, 1'b1, 1'b0});
    tick();
    check_val("one_done", {a_rd, a_busy, a_done}, {1'b0, 1'b0, 1'b1});
    tick();
    check_val("one_done_end", a_done, 0);

    rd_en = 1'b1;
    wr_en = 1'b1;
    tick();
    quiet();
    check_val("conf_wr", a_wr, 1);
    check_val("conf_rd", a_rd, 0);
    check_val("conf_flag", a_conflict, 1);
    tick();
    check_val("conf_end", {a_wr, a_conflict}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
